// File: rtl/scan_ctrl_core.sv
// -----------------------------------------------------------------------------
// scan_ctrl_core
//
// Purpose:
//   A bank of LANES replicated functional cores, each holding two state flops
//   (qB, qC), stitched into one scan chain of CHAIN_LEN = 2*LANES bits and
//   driven by a small test controller.  On a test_start request the
//   controller serially loads the chain, runs one functional capture cycle,
//   then serially unloads the captured state on scan_out.
//
//   Chain bit 2l is lane l qB; chain bit 2l+1 is lane l qC.
//
// Optional feature (macro SCAN_CTRL_SISR_EN):
//   When defined, a 16-bit serial-input signature register compresses the
//   unloaded scan stream (polynomial 16'h1021, seeded 16'hFFFF when a
//   sequence starts).  When undefined, signature is tied to zero.
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous active-high reset
//   A           in   LANES  functional primary input, one bit per lane
//   test_start  in   1      request one load/capture/unload sequence
//   scan_in     in   1      serial scan data, sampled while loading
//   K           out  LANES  functional primary output per lane
//   scan_out    out  1      last chain bit
//   scan_valid  out  1      scan_out carries unload data
//   busy        out  1      controller is not idle
//   done        out  1      one-cycle pulse after the unload completes
//   signature   out  16     signature register contents
// -----------------------------------------------------------------------------
module scan_ctrl_core #(
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LANES-1:0] A,
    input  logic             test_start,
    input  logic             scan_in,
    output logic [LANES-1:0] K,
    output logic             scan_out,
    output logic             scan_valid,
    output logic             busy,
    output logic             done,
    output logic [15:0]      signature
);

    localparam int CHAIN_LEN = 2 * LANES;
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CAPTURE,
        UNLOAD
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CHAIN_LEN-1:0] chain;
    logic [CHAIN_LEN-1:0] chain_next;
    logic [CHAIN_LEN-1:0] func_next;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_next;
    logic                 done_next;

    // Per-lane combinational core.  func_next holds the value each lane's
    // flops take on a functional clock; K is derived from the same B/C terms
    // so it follows the chain contents in every controller state.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic d;
        assign d                = chain[2*l] | chain[2*l+1];
        assign func_next[2*l]   = A[l] & d;
        assign func_next[2*l+1] = ~d;
        assign K[l]             = ~(func_next[2*l] | func_next[2*l+1]);
    end

    assign scan_out   = chain[CHAIN_LEN-1];
    assign busy       = (state != IDLE);
    assign scan_valid = (state == UNLOAD);

    // State, chain, bit counter and done flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            chain <= '0;
            count <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            chain <= chain_next;
            count <= count_next;
            done  <= done_next;
        end
    end

    // Controller next-state logic.  The counter is cleared on every state
    // change so each shifting phase starts counting from zero, and it stops
    // at CHAIN_LEN-1 because that cycle's shift is the last one.
    always_comb begin
        state_next = state;
        chain_next = chain;
        count_next = count;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                chain_next = func_next;
                if (test_start) begin
                    state_next = LOAD;
                    count_next = '0;
                end
            end
            LOAD: begin
                chain_next = {chain[CHAIN_LEN-2:0], scan_in};
                count_next = count + CNT_W'(1);
                if (count == LAST_BIT) begin
                    state_next = CAPTURE;
                    count_next = '0;
                end
            end
            CAPTURE: begin
                chain_next = func_next;
                state_next = UNLOAD;
                count_next = '0;
            end
            UNLOAD: begin
                chain_next = {chain[CHAIN_LEN-2:0], 1'b0};
                count_next = count + CNT_W'(1);
                if (count == LAST_BIT) begin
                    state_next = IDLE;
                    count_next = '0;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

`ifdef SCAN_CTRL_SISR_EN
    logic [15:0] sig;
    logic        fb;

    assign fb = sig[15] ^ scan_out;

    // Signature register: reseeded when a sequence is accepted, folds in
    // one unload bit per UNLOAD cycle, and holds its value otherwise so the
    // result of the last sequence stays readable while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= 16'hFFFF;
        end else if (state == IDLE && test_start) begin
            sig <= 16'hFFFF;
        end else if (state == UNLOAD) begin
            sig <= {sig[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
    end

    assign signature = sig;
`else
    assign signature = 16'h0000;
`endif

endmodule
